// File: rtl/reg_file_banked.sv
// Banked register file for the single-cycle datapath.
// User bank: two registered read ports with write-first bypass and a hardwired zero register.
// Reserved bank: six scratch registers on the sys port, PC and CPSR with dedicated controls.
module reg_file_banked #(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 3,
    parameter int              ZERO_REG = 7,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter logic [DATA_W-1:0] PC_STEP  = DATA_W'(4)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pc_inc,
    input  logic              pc_load,
    input  logic [DATA_W-1:0] pc_load_val,
    output logic [DATA_W-1:0] pc,
    input  logic              flags_we,
    input  logic [3:0]        flags_in,
    output logic [DATA_W-1:0] cpsr,
    input  logic [2:0]        sys_addr,
    input  logic              sys_wr_en,
    input  logic [DATA_W-1:0] sys_wr_data,
    output logic [DATA_W-1:0] sys_rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Zero register only exists when its index falls inside the user bank.
    localparam bit                ZERO_EN  = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] user_regs [DEPTH];
    logic [DATA_W-1:0] sys_regs  [6];
    logic [3:0]        nzcv;

    logic              user_wr_ok;
    logic              sys_wr_ok;
    logic              zero_rd1;
    logic              zero_rd2;
    logic [DATA_W-1:0] rd_next1;
    logic [DATA_W-1:0] rd_next2;
    logic [DATA_W-1:0] sys_next;

    assign user_wr_ok = wr_en && !(ZERO_EN && (wr_addr == ZERO_IDX));
    assign sys_wr_ok  = sys_wr_en && (sys_addr < 3'd6);
    assign zero_rd1   = ZERO_EN && (rd_addr1 == ZERO_IDX);
    assign zero_rd2   = ZERO_EN && (rd_addr2 == ZERO_IDX);

    assign cpsr = {nzcv, {(DATA_W-4){1'b0}}};

    // Next read values: zero register first, then same-edge write bypass, then storage.
    always_comb begin
        rd_next1 = user_regs[rd_addr1];
        rd_next2 = user_regs[rd_addr2];
        sys_next = '0;
        if (zero_rd1)
            rd_next1 = '0;
        else if (wr_en && (wr_addr == rd_addr1))
            rd_next1 = wr_data;
        if (zero_rd2)
            rd_next2 = '0;
        else if (wr_en && (wr_addr == rd_addr2))
            rd_next2 = wr_data;
        case (sys_addr)
            3'd6:    sys_next = pc;
            3'd7:    sys_next = cpsr;
            default: sys_next = (sys_wr_en) ? sys_wr_data : sys_regs[sys_addr];
        endcase
    end

    // User bank storage and registered read ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                user_regs[i] <= '0;
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else begin
            if (user_wr_ok)
                user_regs[wr_addr] <= wr_data;
            rd_data1 <= rd_next1;
            rd_data2 <= rd_next2;
        end
    end

    // Reserved scratch storage and registered sys read port; PC/CPSR are not sys-writable.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++)
                sys_regs[i] <= '0;
            sys_rd_data <= '0;
        end else begin
            if (sys_wr_ok)
                sys_regs[sys_addr] <= sys_wr_data;
            sys_rd_data <= sys_next;
        end
    end

    // PC: load beats increment; increment wraps modulo 2**DATA_W.
    always_ff @(posedge clk) begin
        if (rst)
            pc <= PC_RESET;
        else if (pc_load)
            pc <= pc_load_val;
        else if (pc_inc)
            pc <= pc + PC_STEP;
    end

    // CPSR NZCV field; the remaining bits are tied to zero.
    always_ff @(posedge clk) begin
        if (rst)
            nzcv <= '0;
        else if (flags_we)
            nzcv <= flags_in;
    end

endmodule

// File: tb/tb_reg_file_banked.sv
// Directed bench for reg_file_banked with default parameters.
module tb_reg_file_banked;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd_addr1, rd_addr2, wr_addr, sys_addr;
    logic [31:0] rd_data1, rd_data2, wr_data, pc_load_val, pc, cpsr;
    logic [31:0] sys_wr_data, sys_rd_data;
    logic        wr_en, pc_inc, pc_load, flags_we, sys_wr_en;
    logic [3:0]  flags_in;

    int checks = 0;
    int errors = 0;

    reg_file_banked dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val), .pc(pc),
        .flags_we(flags_we), .flags_in(flags_in), .cpsr(cpsr),
        .sys_addr(sys_addr), .sys_wr_en(sys_wr_en),
        .sys_wr_data(sys_wr_data), .sys_rd_data(sys_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        pc_inc = 1'b0; pc_load = 1'b0; pc_load_val = '0;
        flags_we = 1'b0; flags_in = '0;
        sys_addr = '0; sys_wr_en = 1'b0; sys_wr_data = '0;
        tick();
        rst = 1'b0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_cpsr", cpsr, 32'h0);
        chk("rst_rd1", rd_data1, 32'h0);
        chk("rst_rd2", rd_data2, 32'h0);
        chk("rst_sys", sys_rd_data, 32'h0);

        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEADBEEF;
        tick();
        wr_addr = 3'd4; wr_data = 32'h12345678;
        tick();
        wr_en = 1'b0; rd_addr1 = 3'd3; rd_addr2 = 3'd4;
        tick();
        chk("rd_r3", rd_data1, 32'hDEADBEEF);
        chk("rd_r4", rd_data2, 32'h12345678);

        rd_addr1 = 3'd4; rd_addr2 = 3'd4;
        tick();
        chk("same1", rd_data1, 32'h12345678);
        chk("same2", rd_data2, 32'h12345678);

        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hA5A5A5A5;
        rd_addr1 = 3'd2; rd_addr2 = 3'd3;
        tick();
        chk("bypass", rd_data1, 32'hA5A5A5A5);
        chk("nobypass", rd_data2, 32'hDEADBEEF);

        wr_addr = 3'd7; wr_data = 32'hFFFFFFFF; rd_addr1 = 3'd7; rd_addr2 = 3'd2;
        tick();
        chk("zero_bypass", rd_data1, 32'h0);
        chk("r2_stored", rd_data2, 32'hA5A5A5A5);
        wr_en = 1'b0;
        tick();
        chk("zero_read", rd_data1, 32'h0);

        pc_inc = 1'b1;
        tick();
        chk("pc_inc1", pc, 32'h4);
        tick();
        tick();
        chk("pc_inc3", pc, 32'hC);
        pc_load = 1'b1; pc_load_val = 32'h100;
        tick();
        chk("pc_load_wins", pc, 32'h100);
        pc_inc = 1'b0; pc_load_val = 32'hFFFFFFFC;
        tick();
        chk("pc_load", pc, 32'hFFFFFFFC);
        pc_load = 1'b0; pc_inc = 1'b1;
        tick();
        chk("pc_wrap", pc, 32'h0);
        pc_inc = 1'b0;
        tick();
        chk("pc_hold", pc, 32'h0);

        flags_we = 1'b1; flags_in = 4'b1010;
        tick();
        chk("cpsr_set", cpsr, 32'hA0000000);
        flags_we = 1'b0; flags_in = 4'b0101;
        tick();
        chk("cpsr_hold", cpsr, 32'hA0000000);
        sys_addr = 3'd7;
        tick();
        chk("sys_cpsr", sys_rd_data, 32'hA0000000);

        pc_load = 1'b1; pc_load_val = 32'h40;
        tick();
        pc_load = 1'b0; sys_addr = 3'd6;
        tick();
        chk("sys_pc", sys_rd_data, 32'h40);

        sys_addr = 3'd5; sys_wr_en = 1'b1; sys_wr_data = 32'h55;
        tick();
        chk("sys_bypass", sys_rd_data, 32'h55);
        sys_wr_en = 1'b0;
        tick();
        chk("sys_stored", sys_rd_data, 32'h55);

        sys_addr = 3'd6; sys_wr_en = 1'b1; sys_wr_data = 32'h999;
        tick();
        chk("sys_wr6_pc", pc, 32'h40);
        chk("sys_wr6_rd", sys_rd_data, 32'h40);
        sys_addr = 3'd7; sys_wr_data = 32'h12345678;
        tick();
        sys_wr_en = 1'b0;
        chk("sys_wr7_cpsr", cpsr, 32'hA0000000);

        rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h77;
        pc_inc = 1'b1; flags_we = 1'b1; flags_in = 4'b1111;
        sys_addr = 3'd5;
        tick();
        rst = 1'b0; wr_en = 1'b0; pc_inc = 1'b0; flags_we = 1'b0;
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_cpsr", cpsr, 32'h0);
        chk("rst2_rd1", rd_data1, 32'h0);
        chk("rst2_sys", sys_rd_data, 32'h0);
        rd_addr1 = 3'd1; rd_addr2 = 3'd3;
        tick();
        chk("rst2_r1", rd_data1, 32'h0);
        chk("rst2_r3", rd_data2, 32'h0);
        chk("rst2_s5", sys_rd_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
